// File: rtl/ram_be.sv
// Simple-dual-port RAM with per-byte write enables, 1- or 2-cycle read latency
// and a built-in clear engine that zeroes the array after reset or on request.
module ram_be #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              wEn,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wDat,
    input  logic [DATA_W/8-1:0] wBe,
    input  logic              rEn,
    input  logic [ADDR_W-1:0] rAddr,
    output logic [DATA_W-1:0] rDat,
    output logic              rVld,
    output logic              busy
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                busy_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rdat_q;
    logic                rvld_q;
    logic                acc_ok;
    logic                wr_acc;
    logic                rd_acc;

    // A clear request pre-empts any access sampled on the same edge.
    assign acc_ok = !busy_q && !clr;
    assign wr_acc = acc_ok && wEn;
    assign rd_acc = acc_ok && rEn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (busy_q) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (wBe[i]) begin
                    mem[wAddr][8*i +: 8] <= wDat[8*i +: 8];
                end
            end
        end
    end

    // Write-first mode forwards only the enabled bytes of a colliding write.
    always_comb begin
        rd_word = mem[rAddr];
        if (RDW_MODE == 1 && wr_acc && (wAddr == rAddr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wBe[i]) begin
                    rd_word[8*i +: 8] = wDat[8*i +: 8];
                end
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rdat_q <= '0;
                rvld_q <= 1'b0;
            end else begin
                rvld_q <= rd_acc;
                if (rd_acc) begin
                    rdat_q <= rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic [DATA_W-1:0] p1_dat_q;
        logic              p1_vld_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                p1_dat_q <= '0;
                p1_vld_q <= 1'b0;
                rdat_q   <= '0;
                rvld_q   <= 1'b0;
            end else begin
                p1_vld_q <= rd_acc;
                if (rd_acc) begin
                    p1_dat_q <= rd_word;
                end
                rvld_q <= p1_vld_q;
                if (p1_vld_q) begin
                    rdat_q <= p1_dat_q;
                end
            end
        end
    end

    assign rDat = rdat_q;
    assign rVld = rvld_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ram_be.sv
// Scoreboard bench for ram_be: a read-first/RD_LAT=1 instance and a
// write-first/RD_LAT=2 instance share stimulus, each with its own expect queue.
module tb_ram_be;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clr   = 1'b0;
    logic          wEn   = 1'b0;
    logic [AW-1:0] wAddr = '0;
    logic [DW-1:0] wDat  = '0;
    logic [3:0]    wBe   = '0;
    logic          rEn   = 1'b0;
    logic [AW-1:0] rAddr = '0;
    logic [DW-1:0] rDat_a, rDat_b;
    logic          rVld_a, rVld_b, busy_a, busy_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   done    = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];

    ram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RDW_MODE(0)) u_dut_a (
        .clock(clock), .reset(reset), .clr(clr), .wEn(wEn), .wAddr(wAddr), .wDat(wDat),
        .wBe(wBe), .rEn(rEn), .rAddr(rAddr), .rDat(rDat_a), .rVld(rVld_a), .busy(busy_a)
    );

    ram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RDW_MODE(1)) u_dut_b (
        .clock(clock), .reset(reset), .clr(clr), .wEn(wEn), .wAddr(wAddr), .wDat(wDat),
        .wBe(wBe), .rEn(rEn), .rAddr(rAddr), .rDat(rDat_b), .rVld(rVld_b), .busy(busy_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        rEn   = 1'b1;
        rAddr = a;
        q_a.push_back('{data: ea, due: cyc + 1});
        q_b.push_back('{data: eb, due: cyc + 2});
        tick();
        rEn = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        wEn   = 1'b1;
        wAddr = a;
        wDat  = d;
        wBe   = be;
        tick();
        wEn = 1'b0;
    endtask

    task automatic rdwr(input logic [AW-1:0] ra, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                        input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [3:0] be);
        wEn   = 1'b1;
        wAddr = wa;
        wDat  = d;
        wBe   = be;
        rd(ra, ea, eb);
        wEn = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy_a"}, busy_a, 1);
        check({tag, "_busy_b"}, busy_b, 1);
        check({tag, "_rvld_a"}, rVld_a, 0);
        check({tag, "_rvld_b"}, rVld_b, 0);
        check({tag, "_rdat_a"}, rDat_a, 0);
        check({tag, "_rdat_b"}, rDat_b, 0);
    endtask

    // Counts edges taken while busy is high; both instances must report DEPTH.
    task automatic wait_busy(input string tag);
        int  na = 0;
        int  nb = 0;
        int  n  = 0;
        bit  ba, bb;
        while ((busy_a || busy_b) && n < 100) begin
            ba = busy_a;
            bb = busy_b;
            @(posedge clock);
            #1;
            n++;
            if (ba) na++;
            if (bb) nb++;
        end
        check({tag, "_a"}, na, 16);
        check({tag, "_b"}, nb, 16);
    endtask

    task automatic stimulus();
        repeat (3) @(negedge clock);
        reset_checks("reset_hold");
        reset = 1'b0;
        wait_busy("busy_after_reset");
        @(negedge clock);
        for (int a = 0; a < 16; a++) rd(AW'(a), 32'h0, 32'h0);
        repeat (4) tick();

        wr(5, 32'hAABBCCDD, 4'b1111);
        wr(5, 32'h11223344, 4'b0101);
        rd(5, 32'hAA22CC44, 32'hAA22CC44);

        wr(7, 32'hDEADBEEF, 4'b1111);
        rdwr(7, 32'hDEADBEEF, 32'h12345678, 7, 32'h12345678, 4'b1111);
        rd(7, 32'h12345678, 32'h12345678);
        rdwr(7, 32'h12345678, 32'h1234AAAA, 7, 32'hAAAAAAAA, 4'b0011);
        rd(7, 32'h1234AAAA, 32'h1234AAAA);
        rdwr(5, 32'hAA22CC44, 32'hAA22CC44, 8, 32'hCAFEF00D, 4'b1111);
        rd(8, 32'hCAFEF00D, 32'hCAFEF00D);

        // In-flight read of addr 8 must survive the clear that follows it.
        rd(8, 32'hCAFEF00D, 32'hCAFEF00D);
        clr   = 1'b1;
        wEn   = 1'b1;
        wAddr = 3;
        wDat  = 32'hFFFFFFFF;
        wBe   = 4'b1111;
        rEn   = 1'b1;
        rAddr = 5;
        tick();
        check("busy_after_clr", busy_a, 1);
        wait_busy("busy_clr_window");
        clr = 1'b0;
        wEn = 1'b0;
        rEn = 1'b0;
        @(negedge clock);
        for (int a = 0; a < 16; a++) rd(AW'(a), 32'h0, 32'h0);
        repeat (4) tick();

        wr(1, 32'h11111111, 4'b1111);
        wr(2, 32'h22222222, 4'b1111);
        wr(3, 32'h33333333, 4'b1111);
        rd(1, 32'h11111111, 32'h11111111);
        rd(2, 32'h22222222, 32'h22222222);
        rd(3, 32'h33333333, 32'h33333333);
        repeat (4) tick();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        reset_checks("reset_mid_clear");
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_busy("busy_after_mid_clear_reset");
        @(negedge clock);

        wr(9, 32'h5A5A5A5A, 4'b1111);
        rEn   = 1'b1;
        rAddr = 9;
        @(posedge clock);
        #1;
        check("pre_reset_rdat_a", rDat_a, 32'h5A5A5A5A);
        reset = 1'b1;
        #1;
        reset_checks("reset_mid_read");
        rEn = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_busy("busy_after_mid_read_reset");
        @(negedge clock);
        rd(9, 32'h0, 32'h0);
        repeat (4) tick();
        done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        while (!done) begin
            @(negedge clock);
            if (!reset) begin
                if (rVld_a) begin
                    if (q_a.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL a_unexpected_rvld: got rVld=1 at cycle %0d, expected 0", cyc);
                    end else begin
                        e = q_a.pop_front();
                        check("a_rdat", rDat_a, e.data);
                        check("a_latency", cyc, e.due);
                    end
                end
                if (q_a.size() != 0 && q_a[0].due < cyc) begin
                    e = q_a.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_missing_rvld: got no rVld by cycle %0d, expected at %0d", cyc, e.due);
                end
                if (rVld_b) begin
                    if (q_b.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL b_unexpected_rvld: got rVld=1 at cycle %0d, expected 0", cyc);
                    end else begin
                        e = q_b.pop_front();
                        check("b_rdat", rDat_b, e.data);
                        check("b_latency", cyc, e.due);
                    end
                end
                if (q_b.size() != 0 && q_b[0].due < cyc) begin
                    e = q_b.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_missing_rvld: got no rVld by cycle %0d, expected at %0d", cyc, e.due);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_be.md
# ram_be

Parametrised simple-dual-port synchronous RAM with per-byte write enables, selectable read latency, and a read-valid strobe. Its built-in clear engine zeroes the whole array after reset or on request, with no software involvement. It is the general-purpose storage block for the datapath: one write port and one independent read port on a single clock. It replaces the fixed 512×32 single-address memory in new designs.

## Interface
- `DATA_W`, default 32: word width in bits; must be a multiple of 8.
- `ADDR_W`, default 9: address width; depth is `DEPTH = 2**ADDR_W` words.
- `RD_LAT`, default 1: read latency in clock edges; only 1 or 2 is legal.
- `RDW_MODE`, default 0: same-address read/write behaviour. 0 = read-first (old data); 1 = write-first (new data forwarded per byte).
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clr`  in  1  single-cycle request to re-zero the whole array.
- `wEn`  in  1  write request.
- `wAddr`  in  ADDR_W  write address.
- `wDat`  in  DATA_W  write data.
- `wBe`  in  DATA_W/8  byte enables; bit i covers `wDat[8i+7:8i]`.
- `rEn`  in  1  read request.
- `rAddr`  in  ADDR_W  read address.
- `rDat`  out  DATA_W  read data; holds its last value when no read completes.
- `rVld`  out  1  high for exactly one cycle when `rDat` carries a completed read.
- `busy`  out  1  high while the clear engine owns the array.

## Operation
- FSM states are IDLE and CLEAR. A clear counter `cnt` is ADDR_W bits wide.
- While `reset` is asserted:
  - state = CLEAR, `cnt` = 0;
  - `busy` = 1, `rVld` = 0, `rDat` = 0;
  - the read pipeline is flushed.
- CLEAR:
  - each edge writes all-zero to `mem[cnt]` and increments `cnt`;
  - on the edge that writes `DEPTH-1`, `cnt` wraps to 0 and the state goes to IDLE.
- IDLE → CLEAR when `clr` = 1 at an edge. `cnt` starts at 0.
- `busy` is 1 exactly when state = CLEAR.
- While `busy` = 1, `wEn`, `rEn` and `clr` are ignored: no write, no new read, no restart.
- `clr` has priority. In the edge that samples `clr` = 1 in IDLE, same-cycle `wEn` and `rEn` are ignored.
- Write, in IDLE with `wEn` = 1: for each i with `wBe[i]` = 1, byte i of `mem[wAddr]` takes byte i of `wDat`. Other bytes are unchanged. `wBe` = 0 is a no-op.
- Read, in IDLE with `rEn` = 1: samples `mem[rAddr]` and launches a read down the pipeline.
- A read and a write to different addresses in the same cycle are fully independent.
- Same address, same cycle:
  - `RDW_MODE` = 0 returns the pre-write word;
  - `RDW_MODE` = 1 returns `wDat` bytes where `wBe` = 1 and old bytes elsewhere.
- Reads already in flight when a clear starts complete normally, carrying their pre-clear data.
- Reads launched after the clear ends return post-clear contents.
- Addresses are always in range (DEPTH = 2^ADDR_W), so no bounds checking is needed.

## Timing
- RD_LAT = 1: a read sampled at edge N gives `rDat`/`rVld` valid after edge N, i.e. during cycle N+1.
- RD_LAT = 2: the data passes through one internal register first and is valid after edge N+1.
- Throughput is one read and one write per cycle. Back-to-back reads give `rVld` high on consecutive cycles.
- After `reset` deasserts, `busy` stays high for exactly DEPTH rising edges. The first accepted access is on edge DEPTH+1.
- After `clr` is sampled at edge N, `busy` is high from edge N through edge N+DEPTH. The array reads all-zero from edge N+DEPTH onward.
- `reset` asserted mid-clear or mid-read:
  - immediately sets `busy` = 1, `rVld` = 0, `rDat` = 0;
  - after release, the clear restarts from address 0.
- `rVld` never rises for reads that were ignored while `busy` was high.

## Test plan
- Reset release with ADDR_W = 4: `busy` high for 16 edges. Then reads of all 16 addresses return 0, with `rVld` high one edge (RD_LAT = 1) or two edges (RD_LAT = 2) after each `rEn`.
- Write `wDat` = 32'hAABBCCDD, `wBe` = 4'b1111 to addr 5. Then write 32'h11223344 with `wBe` = 4'b0101 to addr 5. Read addr 5 → 32'hAA22CC44.
- Same-cycle write 32'h12345678 (`wBe` = 4'b1111) and read at addr 7, which holds 32'hDEADBEEF. `RDW_MODE` = 0 → 32'hDEADBEEF; `RDW_MODE` = 1 → 32'h12345678. A following read returns 32'h12345678 in both modes.
- Pulse `clr` with a same-cycle write of 32'hFFFFFFFF to addr 3. The write is dropped. `busy` is high for DEPTH edges, and reads and writes during that window are ignored with no `rVld`. Afterwards, addr 3 and all other addresses read 0.
- RD_LAT = 2, reads issued to addr 1, 2, 3 on consecutive edges → `rVld` high for three consecutive cycles starting two edges after the first read, with data in order.
- Assert `reset` mid-clear at `cnt` = 6 and mid-read. `rVld`/`rDat` drop to 0 immediately. After release, `busy` again lasts the full DEPTH edges.
